// File: rtl/thread_exec_unit.sv
// Per-thread execution unit: serially loaded register file, single-cycle ALU ops,
// and a restoring divider that retires one quotient bit per cycle.
module thread_exec_unit #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = $clog2(NUM_REGS),
    parameter int SH_W     = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [REG_AW-1:0] load_idx,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        opcode,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic [SH_W-1:0]   shamt,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic [REG_AW-1:0] result_rd,
    output logic              illegal_op,
    output logic              thread_complete,
    output logic              busy
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_UDIV = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_SRL  = 4'h8;
    localparam logic [3:0] OP_END  = 4'hF;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXEC, S_DIV, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [SH_W-1:0]   cnt_q, cnt_d;
    logic [REG_AW-1:0] div_rd_q, div_rd_d;
    logic              res_vld_q, res_vld_d, ill_q, ill_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [REG_AW-1:0] res_rd_q, res_rd_d;

    logic              wr_en;
    logic [REG_AW-1:0] wr_idx;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] op_a, op_b, alu_res;
    logic [DATA_W:0]   trial;
    logic              div_ge;
    logic [DATA_W-1:0] rem_step, dvd_step;

    function automatic logic in_range(input logic [REG_AW-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    // Indices past NUM_REGS read as zero and are never written.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (in_range(rs1)) op_a = regs_q[rs1];
        if (in_range(rs2)) op_b = regs_q[rs2];
    end

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_MUL:  alu_res = op_a * op_b;
            OP_UDIV: alu_res = '1;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLL:  alu_res = op_a << shamt;
            OP_SRL:  alu_res = op_a >> shamt;
            default: alu_res = '0;
        endcase
    end

    // Restoring step: the dividend register shifts out its MSB and fills with quotient bits.
    always_comb begin
        trial    = {rem_q, dvd_q[DATA_W-1]};
        div_ge   = trial >= {1'b0, dvs_q};
        rem_step = div_ge ? (trial[DATA_W-1:0] - dvs_q) : trial[DATA_W-1:0];
        dvd_step = {dvd_q[DATA_W-2:0], div_ge};
    end

    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        div_rd_d   = div_rd_q;
        res_vld_d  = 1'b0;
        ill_d      = 1'b0;
        res_data_d = res_data_q;
        res_rd_d   = res_rd_q;
        wr_en      = 1'b0;
        wr_idx     = rd;
        wr_data    = alu_res;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                wr_idx  = load_idx;
                wr_data = load_data;
                if (load_valid) begin
                    wr_en = in_range(load_idx);
                    if (load_last) state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (instr_valid) begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                            wr_en     = in_range(rd);
                            res_vld_d = 1'b1;
                        end
                        OP_UDIV: begin
                            if (op_b == '0) begin
                                wr_en     = in_range(rd);
                                res_vld_d = 1'b1;
                            end else begin
                                dvd_d    = op_a;
                                dvs_d    = op_b;
                                rem_d    = '0;
                                cnt_d    = '0;
                                div_rd_d = rd;
                                state_d  = S_DIV;
                            end
                        end
                        OP_END:  state_d = S_DONE;
                        default: ill_d = 1'b1;
                    endcase
                    if (res_vld_d) begin
                        res_data_d = alu_res;
                        res_rd_d   = rd;
                    end
                end
            end
            S_DIV: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SH_W'(DATA_W - 1)) begin
                    wr_en      = in_range(div_rd_q);
                    wr_idx     = div_rd_q;
                    wr_data    = dvd_step;
                    res_vld_d  = 1'b1;
                    res_data_d = dvd_step;
                    res_rd_d   = div_rd_q;
                    state_d    = S_EXEC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            div_rd_q   <= '0;
            res_vld_q  <= 1'b0;
            ill_q      <= 1'b0;
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            if (wr_en) regs_q[wr_idx] <= wr_data;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            div_rd_q   <= div_rd_d;
            res_vld_q  <= res_vld_d;
            ill_q      <= ill_d;
            res_data_q <= res_data_d;
            res_rd_q   <= res_rd_d;
        end
    end

    assign load_ready      = (state_q == S_LOAD);
    assign instr_ready     = (state_q == S_EXEC);
    assign thread_complete = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy            = (state_q == S_LOAD) || (state_q == S_EXEC) || (state_q == S_DIV);
    assign result_valid    = res_vld_q;
    assign result_data     = res_data_q;
    assign result_rd       = res_rd_q;
    assign illegal_op      = ill_q;

endmodule

// File: tb/tb_thread_exec_unit.sv
// Bench for thread_exec_unit: cycle-level behavioural model compared every cycle,
// plus directed literal checks on the specific scenarios.
module tb_thread_exec_unit;
    localparam int DW = 32;
    localparam int NR = 24;
    localparam int AW = $clog2(NR);
    localparam int SW = $clog2(DW);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_idx;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          instr_valid;
    logic          instr_ready;
    logic [3:0]    opcode;
    logic [AW-1:0] rs1, rs2, rd;
    logic [SW-1:0] shamt;
    logic          result_valid;
    logic [DW-1:0] result_data;
    logic [AW-1:0] result_rd;
    logic          illegal_op;
    logic          thread_complete;
    logic          busy;

    thread_exec_unit #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
        .load_data(load_data), .load_last(load_last),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .shamt(shamt),
        .result_valid(result_valid), .result_data(result_data), .result_rd(result_rd),
        .illegal_op(illegal_op), .thread_complete(thread_complete), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int pcyc   = 0;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every result pulse, with the cycle it was seen in.
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];
    always @(negedge clk) begin
        if (result_valid === 1'b1) begin
            log_data.push_back(result_data);
            log_cyc.push_back(pcyc);
        end
    end

    // Behavioural model, advanced once per cycle from the inputs seen mid-cycle.
    localparam int P_IDLE = 0, P_LOAD = 1, P_EXEC = 2, P_DIV = 3, P_DONE = 4;
    int            m_phase;
    logic [DW-1:0] mreg [NR];
    logic          m_rv, m_ill;
    logic [DW-1:0] m_rdata, m_quot;
    logic [AW-1:0] m_rrd, m_drd;
    int            m_left;

    task automatic model_reset();
        m_phase = P_IDLE;
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        m_rv = 1'b0; m_ill = 1'b0; m_rdata = '0; m_rrd = '0; m_left = 0;
    endtask

    task automatic write_result(input logic [AW-1:0] dst, input logic [DW-1:0] val);
        if (int'(dst) < NR) mreg[dst] = val;
        m_rv = 1'b1; m_rdata = val; m_rrd = dst;
    endtask

    task automatic model_step();
        logic [DW-1:0] a, b, r;
        logic wr;
        m_rv = 1'b0; m_ill = 1'b0;
        case (m_phase)
            P_IDLE, P_DONE: if (start) m_phase = P_LOAD;
            P_LOAD: if (load_valid) begin
                if (int'(load_idx) < NR) mreg[load_idx] = load_data;
                if (load_last) m_phase = P_EXEC;
            end
            P_EXEC: if (instr_valid) begin
                a  = (int'(rs1) < NR) ? mreg[rs1] : '0;
                b  = (int'(rs2) < NR) ? mreg[rs2] : '0;
                wr = 1'b1;
                r  = '0;
                case (opcode)
                    4'd0: r = a + b;
                    4'd1: r = a - b;
                    4'd2: r = a * b;
                    4'd3: if (b == 0) r = '1;
                          else begin
                              wr = 1'b0; m_quot = a / b; m_drd = rd; m_left = DW; m_phase = P_DIV;
                          end
                    4'd4: r = a & b;
                    4'd5: r = a | b;
                    4'd6: r = a ^ b;
                    4'd7: r = a << shamt;
                    4'd8: r = a >> shamt;
                    4'd15: begin wr = 1'b0; m_phase = P_DONE; end
                    default: begin wr = 1'b0; m_ill = 1'b1; end
                endcase
                if (wr) write_result(rd, r);
            end
            P_DIV: begin
                m_left--;
                if (m_left == 0) begin
                    write_result(m_drd, m_quot);
                    m_phase = P_EXEC;
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst) model_reset();
        chk("result_valid", result_valid, m_rv);
        chk("result_data", result_data, m_rdata);
        chk("result_rd", result_rd, m_rrd);
        chk("illegal_op", illegal_op, m_ill);
        chk("thread_complete", thread_complete, (m_phase == P_IDLE) || (m_phase == P_DONE));
        chk("busy", busy, (m_phase == P_LOAD) || (m_phase == P_EXEC) || (m_phase == P_DIV));
        chk("load_ready", load_ready, m_phase == P_LOAD);
        chk("instr_ready", instr_ready, m_phase == P_EXEC);
        if (rst) model_step();
    end

    task automatic settle();
        @(posedge clk); #1;
    endtask

    task automatic start_thread();
        start = 1'b1;
        settle();
        start = 1'b0;
    endtask

    task automatic load_word(input int idx, input logic [DW-1:0] data, input logic last);
        bit ok = 1'b0;
        load_valid = 1'b1; load_idx = AW'(idx); load_data = data; load_last = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (load_ready) begin ok = 1'b1; break; end
        end
        if (ok) settle();
        else chk("load_timeout", 0, 1);
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic issue(input int op, input int d, input int s1, input int s2, input int sh,
                         output int acc);
        bit ok = 1'b0;
        acc = -1;
        instr_valid = 1'b1; opcode = 4'(op); rd = AW'(d); rs1 = AW'(s1); rs2 = AW'(s2);
        shamt = SW'(sh);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (instr_ready) begin ok = 1'b1; acc = pcyc; break; end
        end
        if (ok) settle();
        else chk("issue_timeout", 0, 1);
        instr_valid = 1'b0;
    endtask

    task automatic pin_result(input string name, input logic [DW-1:0] val, input int dst);
        @(negedge clk); #1;
        chk({name, "_valid"}, result_valid, 1);
        chk({name, "_data"}, result_data, val);
        chk({name, "_rd"}, result_rd, dst);
        settle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, n, nlog;
        rst = 1'b0; start = 1'b0; load_valid = 1'b0; load_idx = '0; load_data = '0;
        load_last = 1'b0; instr_valid = 1'b0; opcode = '0; rs1 = '0; rs2 = '0; rd = '0;
        shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tc", thread_complete, 1);
        chk("reset_result_data", result_data, 0);
        rst = 1'b1;
        settle();

        // Thread 1: load, ADD, dependent SUB/MUL chain, END with a colliding start
        start_thread();
        load_word(1, 32'd5, 1'b0);
        load_word(2, 32'd7, 1'b1);
        issue(0, 3, 1, 2, 0, acc);
        pin_result("add", 32'd12, 3);

        nlog = log_data.size();
        issue(1, 4, 1, 2, 0, acc);
        issue(2, 5, 4, 2, 0, acc);
        @(negedge clk); #1;
        chk("chain_count", log_data.size() - nlog, 2);
        if (log_data.size() - nlog == 2) begin
            chk("chain_sub", log_data[nlog], 32'hFFFF_FFFE);
            chk("chain_mul", log_data[nlog+1], 32'hFFFF_FFF2);
            chk("chain_gap", log_cyc[nlog+1] - log_cyc[nlog], 1);
        end
        settle();

        start = 1'b1;
        issue(15, 0, 0, 0, 0, acc);
        start = 1'b0;
        @(negedge clk); #1;
        chk("end_tc", thread_complete, 1);
        chk("end_instr_ready", instr_ready, 0);
        chk("end_busy", busy, 0);
        repeat (2) settle();
        chk("end_start_ignored", thread_complete, 1);

        // Thread 2: out-of-range load, retention, divide, shifts, illegal op
        start_thread();
        load_word(30, 32'hDEAD_BEEF, 1'b0);
        load_word(6, 32'd1, 1'b0);
        load_word(1, 32'd100, 1'b1);
        issue(0, 12, 3, 2, 0, acc);
        pin_result("retain", 32'd19, 12);
        issue(5, 11, 14, 6, 0, acc);
        pin_result("drop_idx", 32'd1, 11);

        issue(3, 13, 1, 2, 0, acc);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (instr_ready) break;
            n++;
        end
        #1;
        chk("div_busy_cycles", n, 32);
        chk("div_valid", result_valid, 1);
        chk("div_data", result_data, 32'd14);
        chk("div_latency", log_cyc[log_cyc.size()-1] - acc, 33);
        settle();

        issue(3, 15, 1, 14, 0, acc);
        pin_result("div0", 32'hFFFF_FFFF, 15);
        issue(7, 8, 6, 0, 31, acc);
        pin_result("sll", 32'h8000_0000, 8);
        issue(8, 9, 8, 0, 31, acc);
        pin_result("srl", 32'd1, 9);

        issue(9, 16, 1, 2, 0, acc);
        @(negedge clk); #1;
        chk("illegal_pulse", illegal_op, 1);
        chk("illegal_no_result", result_valid, 0);
        settle();
        issue(0, 17, 16, 14, 0, acc);
        pin_result("illegal_no_write", 32'd0, 17);

        // Reset in the middle of a divide
        issue(3, 18, 1, 2, 0, acc);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_div_tc", thread_complete, 1);
        chk("rst_div_busy", busy, 0);
        chk("rst_div_valid", result_valid, 0);
        repeat (2) settle();
        rst = 1'b1;
        nlog = log_data.size();
        repeat (40) settle();
        chk("rst_div_no_result", log_data.size() - nlog, 0);

        // Thread 3: registers must have been cleared by reset
        start_thread();
        load_word(20, 32'd3, 1'b1);
        issue(0, 21, 1, 2, 0, acc);
        pin_result("cleared_add", 32'd0, 21);
        issue(5, 22, 3, 5, 0, acc);
        pin_result("cleared_or", 32'd0, 22);
        repeat (3) settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
